uart_packet_engine: RTL and testbench

Parametrised successor to the UART ALU packet FSM. It sits between the UART RX byte stream and the UART TX byte stream. It parses framed command packets (opcode, reserved, 16-bit length) and then either echoes the payload or reduces N little-endian operands with ADD or MUL. Results return as a status byte followed by a fixed-width result. Unlike the previous block, it accepts any operand count, supports configurable operand and result widths, holds output data stable under backpressure, and reports malformed packets with an error response instead of hanging.

---
 rtl/uart_packet_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_packet_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_engine.sv
// rtl/uart_packet_engine.sv - framed UART command engine: echo, or ADD/MUL reduction of N operands
//
// Purpose:
//   Parses packets of {opcode, reserved, len_lo, len_hi, payload...} from the RX
//   byte stream. len counts the whole packet, including the 4 header bytes.
//   ECHO packets return their payload. ADD/MUL packets reduce the little-endian
//   operands into an accumulator and return status 8'h00 followed by the result,
//   MSB first. Malformed packets are drained and answered with ERR_CODE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   data_i/valid_i      RX byte stream in, ready_o is the engine's accept
//   data_o/valid_o      TX byte stream out, ready_i is the sink's accept
//   busy_o              high whenever a packet is in progress (state != OPCODE)
//   err_o               one-cycle pulse when an error status byte is issued
//   state_o             current state encoding, for debug
module uart_packet_engine #(
  parameter int         OPERAND_BYTES = 4,
  parameter int         RESULT_BYTES  = 8,
  parameter logic [7:0] OP_ECHO       = 8'hEC,
  parameter logic [7:0] OP_ADD        = 8'hAD,
  parameter logic [7:0] OP_MUL        = 8'hA1,
  parameter logic [7:0] ERR_CODE      = 8'hEE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  localparam int          OW       = 8 * OPERAND_BYTES;
  localparam int          AW       = 8 * RESULT_BYTES;
  localparam logic [15:0] OPB      = 16'(OPERAND_BYTES);
  localparam logic [3:0]  OP_LAST  = 4'(OPERAND_BYTES - 1);
  localparam logic [3:0]  RES_LAST = 4'(RESULT_BYTES);
  localparam logic [3:0]  RES_TOP  = 4'(RESULT_BYTES - 1);

  typedef enum logic [2:0] {
    S_OPCODE  = 3'd0,
    S_RSVD    = 3'd1,
    S_LEN_LO  = 3'd2,
    S_LEN_HI  = 3'd3,
    S_ECHO    = 3'd4,
    S_OPERAND = 3'd5,
    S_DRAIN   = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_opcode;
  logic [7:0]      r_len_lo;
  logic [15:0]     r_len;
  logic [15:0]     r_cnt;
  logic            r_err;
  logic [OW-1:0]   r_opnd;
  logic [3:0]      r_op_idx;
  logic            r_op_pend;
  logic            r_first;
  logic [AW-1:0]   r_acc;
  logic [3:0]      r_resp_idx;
  logic [7:0]      r_data_o;
  logic            r_valid_o;
  logic            r_err_o;

  logic            w_ready;
  logic            w_rx;
  logic            w_tx;
  logic [15:0]     w_len_full;
  logic [15:0]     w_payload;
  logic [15:0]     w_cnt_next;
  logic            w_is_arith;
  logic            w_is_echo;
  logic            w_hdr_err;
  logic            w_last_rx;
  logic [3:0]      w_resp_last;
  logic [3:0]      w_byte_sel;
  logic [7:0]      w_acc_byte;
  logic [OW-1:0]   w_opnd_shift;
  logic [AW-1:0]   w_opnd_ext;
  logic            w_to_opcode;

  assign w_rx        = valid_i & w_ready;
  assign w_tx        = r_valid_o & ready_i;
  assign w_len_full  = {data_i, r_len_lo};
  assign w_payload   = w_len_full - 16'd4;
  assign w_cnt_next  = r_cnt + 16'd1;
  assign w_is_arith  = (r_opcode == OP_ADD) | (r_opcode == OP_MUL);
  assign w_is_echo   = (r_opcode == OP_ECHO);
  assign w_last_rx   = (w_cnt_next == r_len);
  assign w_resp_last = r_err ? 4'd0 : RES_LAST;

  // Header validation, evaluated while the length MSB is on data_i.
  assign w_hdr_err = (w_len_full < 16'd4) | ~(w_is_arith | w_is_echo) |
                     (w_is_arith & ((w_payload == 16'd0) | ((w_payload % OPB) != 16'd0)));

  // New bytes enter at the top so the first byte ends up as the operand LSB.
  assign w_opnd_shift = (r_opnd >> 8) | (OW'(data_i) << (OW - 8));
  assign w_opnd_ext   = AW'(r_opnd);

  // r_resp_idx names the byte currently held on data_o (0 = status); the byte
  // loaded on a transfer is the next one, taken MSB first from the accumulator.
  assign w_byte_sel = RES_TOP - r_resp_idx;
  assign w_acc_byte = 8'(r_acc >> {w_byte_sel, 3'b000});

  assign w_to_opcode = (r_state != S_OPCODE) && (w_next == S_OPCODE);

  assign ready_o = w_ready;
  assign data_o  = r_data_o;
  assign valid_o = r_valid_o;
  assign err_o   = r_err_o;
  assign busy_o  = (r_state != S_OPCODE);
  assign state_o = {1'b0, r_state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OPCODE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_OPCODE: begin
        w_ready = 1'b1;
        if (valid_i) w_next = S_RSVD;
      end
      S_RSVD: begin
        w_ready = 1'b1;
        if (valid_i) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_ready = 1'b1;
        if (valid_i) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_ready = 1'b1;
        if (valid_i) begin
          // The header is 4 bytes, so after this byte cnt == 4.
          if (w_hdr_err)                   w_next = (w_len_full > 16'd4) ? S_DRAIN : S_RESP;
          else if (w_is_echo)              w_next = (w_len_full == 16'd4) ? S_OPCODE : S_ECHO;
          else                             w_next = S_OPERAND;
        end
      end
      S_ECHO: begin
        // Once the whole packet is in, stop accepting so the next packet's
        // opcode is not swallowed while the last echo byte drains.
        w_ready = (r_cnt != r_len) & (~r_valid_o | ready_i);
        if ((r_cnt == r_len) && (!r_valid_o || ready_i)) w_next = S_OPCODE;
      end
      S_OPERAND: begin
        w_ready = 1'b1;
        if (valid_i && w_last_rx) w_next = S_RESP;
      end
      S_DRAIN: begin
        w_ready = 1'b1;
        if (valid_i && w_last_rx) w_next = S_RESP;
      end
      S_RESP: begin
        w_ready = 1'b0;
        if (w_tx && (r_resp_idx == w_resp_last)) w_next = S_OPCODE;
      end
      default: w_next = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode   <= 8'd0;
      r_len_lo   <= 8'd0;
      r_len      <= 16'd0;
      r_cnt      <= 16'd0;
      r_err      <= 1'b0;
      r_opnd     <= '0;
      r_op_idx   <= 4'd0;
      r_op_pend  <= 1'b0;
      r_first    <= 1'b1;
      r_acc      <= '0;
      r_resp_idx <= 4'd0;
      r_data_o   <= 8'd0;
      r_valid_o  <= 1'b0;
      r_err_o    <= 1'b0;
    end else begin
      r_err_o <= 1'b0;

      // A completed operand folds into the accumulator one cycle later; the
      // earliest RESP byte that reads the accumulator is two cycles out.
      if (r_op_pend) begin
        r_op_pend <= 1'b0;
        r_first   <= 1'b0;
        if (r_first)                 r_acc <= w_opnd_ext;
        else if (r_opcode == OP_MUL) r_acc <= r_acc * w_opnd_ext;
        else                         r_acc <= r_acc + w_opnd_ext;
      end

      if (w_rx) r_cnt <= w_cnt_next;

      case (r_state)
        S_OPCODE: if (w_rx) r_opcode <= data_i;
        S_LEN_LO: if (w_rx) r_len_lo <= data_i;
        S_LEN_HI: if (w_rx) begin
          r_len <= w_len_full;
          r_err <= w_hdr_err;
        end
        S_ECHO: begin
          if (w_rx) begin
            r_data_o  <= data_i;
            r_valid_o <= 1'b1;
          end else if (w_tx) begin
            r_valid_o <= 1'b0;
          end
        end
        S_OPERAND: if (w_rx) begin
          r_opnd <= w_opnd_shift;
          if (r_op_idx == OP_LAST) begin
            r_op_idx  <= 4'd0;
            r_op_pend <= 1'b1;
          end else begin
            r_op_idx <= r_op_idx + 4'd1;
          end
        end
        S_RESP: begin
          if (!r_valid_o) begin
            r_data_o  <= r_err ? ERR_CODE : 8'h00;
            r_valid_o <= 1'b1;
            r_err_o   <= r_err;
          end else if (ready_i) begin
            if (r_resp_idx == w_resp_last) begin
              r_valid_o <= 1'b0;
            end else begin
              r_resp_idx <= r_resp_idx + 4'd1;
              r_data_o   <= w_acc_byte;
            end
          end
        end
        default: ;
      endcase

      if (w_to_opcode) begin
        r_cnt      <= 16'd0;
        r_err      <= 1'b0;
        r_acc      <= '0;
        r_first    <= 1'b1;
        r_op_idx   <= 4'd0;
        r_resp_idx <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_engine.sv
// tb/tb_uart_packet_engine.sv - self-checking bench for uart_packet_engine
module tb_uart_packet_engine;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       err_o;
  logic [3:0] state_o;

  uart_packet_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .err_o   (err_o),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string        name;
    int           n;
    logic [127:0] b;
    int           ne;
    logic [71:0]  e;
    int           eerr;
    int           mode;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] g_pkt[$];
  logic [7:0] g_exp[$];
  int         g_exp_err;
  int         g_mode;
  int         g_gap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int i);
    g_pkt.delete();
    g_exp.delete();
    for (int k = 0; k < vecs[i].n; k++)  g_pkt.push_back(vecs[i].b[127-8*k -: 8]);
    for (int k = 0; k < vecs[i].ne; k++) g_exp.push_back(vecs[i].e[71-8*k -: 8]);
    g_exp_err = vecs[i].eerr;
    g_mode    = vecs[i].mode;
    g_gap     = (vecs[i].mode == 2) ? 1 : 0;
  endtask

  // Reference: what the packet should produce, from the packet rules alone.
  task automatic model();
    logic [7:0]  op;
    int          len;
    bit          arith;
    logic [63:0] acc;
    logic [63:0] v;
    g_exp.delete();
    g_exp_err = 0;
    op    = g_pkt[0];
    len   = int'({g_pkt[3], g_pkt[2]});
    arith = (op == 8'hAD) || (op == 8'hA1);
    if (len < 4 || !(arith || op == 8'hEC) || (arith && (len == 4 || ((len - 4) % 4) != 0))) begin
      g_exp.push_back(8'hEE);
      g_exp_err = 1;
    end else if (op == 8'hEC) begin
      for (int i = 4; i < len; i++) g_exp.push_back(g_pkt[i]);
    end else begin
      acc = 64'd0;
      for (int k = 0; k < (len - 4) / 4; k++) begin
        v = 64'd0;
        for (int b = 0; b < 4; b++) v = v | (64'(g_pkt[4 + 4*k + b]) << (8*b));
        if (k == 0)           acc = v;
        else if (op == 8'hAD) acc = acc + v;
        else                  acc = acc * v;
      end
      g_exp.push_back(8'h00);
      for (int b = 7; b >= 0; b--) g_exp.push_back(acc[8*b +: 8]);
    end
  endtask

  task automatic gen_random();
    int         kind;
    int         len;
    logic [7:0] op;
    kind = int'($urandom_range(0, 5));
    case (kind)
      0: begin op = 8'hAD; len = 4 + 4 * int'($urandom_range(1, 4)); end
      1: begin op = 8'hA1; len = 4 + 4 * int'($urandom_range(1, 3)); end
      2: begin op = 8'hEC; len = 4 + int'($urandom_range(0, 6)); end
      3: begin
        op  = ($urandom_range(0, 1) != 0) ? 8'hAD : 8'hA1;
        len = 4 + int'($urandom_range(1, 11));
        if (((len - 4) % 4) == 0) len++;
      end
      4: begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'hEC || op == 8'hAD || op == 8'hA1) op = 8'h00;
        len = 4 + int'($urandom_range(0, 4));
      end
      default: begin
        op  = ($urandom_range(0, 1) != 0) ? 8'hAD : 8'hEC;
        len = int'($urandom_range(0, 3));
      end
    endcase
    g_pkt.delete();
    g_pkt.push_back(op);
    g_pkt.push_back(8'($urandom));
    g_pkt.push_back(len[7:0]);
    g_pkt.push_back(len[15:8]);
    for (int i = 4; i < len; i++) g_pkt.push_back(8'($urandom));
  endtask

  // Drives g_pkt, collects TX bytes, checks echo latency and hold-under-stall.
  task automatic run_pkt(input string name);
    logic [7:0] got[$];
    int         idx = 0;
    int         cyc = 0;
    int         errs = 0;
    bit         done = 0;
    bit         stall = 0;
    logic [7:0] stall_data = 8'd0;
    bit         echo_acc = 0;
    logic [7:0] echo_byte = 8'd0;
    got.delete();
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (stall) begin
        check({name, "_hold_valid"}, 64'(valid_o), 64'd1);
        check({name, "_hold_data"}, 64'(data_o), 64'(stall_data));
      end
      if (echo_acc) begin
        check({name, "_echo_lat_valid"}, 64'(valid_o), 64'd1);
        check({name, "_echo_lat_data"}, 64'(data_o), 64'(echo_byte));
      end
      case (g_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = cyc[0];
        default: ready_i = ($urandom_range(0, 3) != 0);
      endcase
      if (idx < g_pkt.size() && (g_gap == 0 || $urandom_range(0, 3) != 0)) begin
        valid_i = 1'b1;
        data_i  = g_pkt[idx];
      end else begin
        valid_i = 1'b0;
        data_i  = 8'($urandom);
      end
      #1;
      if (err_o) errs++;
      echo_acc  = (state_o == 4'd4) && valid_i && ready_o;
      echo_byte = data_i;
      if (valid_i && ready_o) idx++;
      if (valid_o && ready_i) got.push_back(data_o);
      stall      = valid_o && !ready_i;
      stall_data = data_o;
      cyc++;
      if (idx == g_pkt.size() && got.size() >= g_exp.size() && state_o == 4'd0 && !valid_o) done = 1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_tx_count"}, 64'(got.size()), 64'(g_exp.size()));
    for (int k = 0; k < g_exp.size() && k < got.size(); k++)
      check($sformatf("%s_tx%0d", name, k), 64'(got[k]), 64'(g_exp[k]));
    check({name, "_err_pulses"}, 64'(errs), 64'(g_exp_err));
    check({name, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int idx;
    int cyc;

    vecs[0] = '{"add2",        12, 128'hAD000C00_01000000_02000000_00000000, 9, 72'h00_00000000_00000003, 0, 0};
    vecs[1] = '{"mul3_toggle", 16, 128'hA1001000_02000000_03000000_07000000, 9, 72'h00_00000000_0000002A, 0, 1};
    vecs[2] = '{"echo3",        7, 128'hEC000700_41424300_00000000_00000000, 3, 72'h414243_00_00000000_00, 0, 2};
    vecs[3] = '{"echo_len4",    4, 128'hEC000400_00000000_00000000_00000000, 0, 72'h0, 0, 0};
    vecs[4] = '{"err_drain",    7, 128'hAD000700_11223300_00000000_00000000, 1, 72'hEE_00000000_00000000, 1, 2};
    vecs[5] = '{"err_unknown",  6, 128'h55000600_AABB0000_00000000_00000000, 1, 72'hEE_00000000_00000000, 1, 0};
    vecs[6] = '{"err_len2",     4, 128'hAD000200_00000000_00000000_00000000, 1, 72'hEE_00000000_00000000, 1, 0};
    vecs[7] = '{"add_ovf",     16, 128'hAD001000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 9, 72'h00_00000002_FFFFFFFD, 0, 2};
    vecs[8] = '{"add_len4",     4, 128'hAD000400_00000000_00000000_00000000, 1, 72'hEE_00000000_00000000, 1, 1};
    vecs[9] = '{"mul1",         8, 128'hA1000800_05000000_00000000_00000000, 9, 72'h00_00000000_00000005, 0, 0};

    rst_n   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data",  64'(data_o),  64'd0);
    check("rst_err",   64'(err_o),   64'd0);
    check("rst_busy",  64'(busy_o),  64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      load_vec(i);
      run_pkt(vecs[i].name);
    end

    // Reset in the middle of an operand.
    load_vec(0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = g_pkt[k];
    end
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("mid_operand_state", 64'(state_o), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    check("mid_operand_rst_state", 64'(state_o), 64'd0);
    check("mid_operand_rst_busy",  64'(busy_o),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_vec(1);
    run_pkt("after_rst_operand");

    // Reset while a response is stalled by the TX side.
    load_vec(0);
    ready_i = 1'b0;
    idx = 0;
    cyc = 0;
    while ((idx < g_pkt.size() || !valid_o) && cyc < 200) begin
      @(negedge clk);
      if (idx < g_pkt.size()) begin
        valid_i = 1'b1;
        data_i  = g_pkt[idx];
      end else begin
        valid_i = 1'b1;
        data_i  = 8'h99;
      end
      #1;
      if (valid_i && ready_o) idx++;
      cyc++;
    end
    check("resp_stall_reached", 64'(valid_o), 64'd1);
    check("resp_state",         64'(state_o), 64'd7);
    check("resp_rx_blocked",    64'(ready_o), 64'd0);
    valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_resp_rst_valid", 64'(valid_o), 64'd0);
    check("mid_resp_rst_data",  64'(data_o),  64'd0);
    check("mid_resp_rst_state", 64'(state_o), 64'd0);
    check("mid_resp_rst_ready", 64'(ready_o), 64'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    load_vec(7);
    run_pkt("after_rst_resp");

    for (int t = 0; t < 40; t++) begin
      gen_random();
      model();
      g_mode = 2;
      g_gap  = 1;
      run_pkt($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
